// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - FETCH/EXEC control sequencer for a small single-issue CPU
//
// Purpose: two-cycle-per-instruction control FSM (IDLE, FETCH, EXEC, HALTED).
// It decodes the opcode during EXEC into datapath controls and counts retired
// instructions.
// Optional feature macro: CTRL_SEQ_STEP_EN. When it is defined, every non-HALT
// EXEC parks in PAUSE until a step pulse arrives.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-high reset
//   start    - level; leaves IDLE when high, ignored elsewhere
//   step     - single-step advance (used only with CTRL_SEQ_STEP_EN)
//   opcode   - current instruction opcode [5:0]
//   zero     - registered zero flag from the datapath
//   s_inc    - PC increment select (0 = take jump target)
//   s_inm    - immediate operand select
//   we       - register-file write enable
//   wez      - zero-flag write enable
//   ALUOp    - ALU operation [2:0]
//   pc_en    - PC register load enable
//   halted   - high while in HALTED
//   retired  - retired-instruction count, wraps
module ctrl_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JZ   = 6'b010001;
  localparam logic [5:0] OP_JNZ  = 6'b010010;
  localparam logic [5:0] OP_HALT = 6'b011111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef CTRL_SEQ_STEP_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3,
    PAUSE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3
  } state_t;

  // step has no function in this build; the port is kept for a uniform pinout.
  logic unused_step;
  assign unused_step = step;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    we        = 1'b0;
    wez       = 1'b0;
    pc_en     = 1'b0;
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    ALUOp     = 3'b000;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end

      FETCH: begin
        state_d = EXEC;
      end

      EXEC: begin
        // Every EXEC retires one instruction, HALT included.
        retired_d = retired_q + CNT_ONE;

        case (opcode[5:3])
          3'b000, 3'b001: begin
            // Register (000) and immediate (001) ALU ops share all controls
            // except the operand select.
            ALUOp = opcode[2:0];
            s_inm = opcode[3];
            we    = 1'b1;
            wez   = 1'b1;
            pc_en = 1'b1;
          end
          default: begin
            case (opcode)
              OP_J: begin
                s_inc = 1'b0;
                pc_en = 1'b1;
              end
              OP_JZ: begin
                s_inc = ~zero;
                pc_en = 1'b1;
              end
              OP_JNZ: begin
                s_inc = zero;
                pc_en = 1'b1;
              end
              OP_HALT: begin
                pc_en = 1'b0;
              end
              default: begin
                pc_en = 1'b1;
              end
            endcase
          end
        endcase

        if (opcode == OP_HALT) begin
          state_d = HALTED;
        end else begin
`ifdef CTRL_SEQ_STEP_EN
          state_d = PAUSE;
`else
          state_d = FETCH;
`endif
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

`ifdef CTRL_SEQ_STEP_EN
      PAUSE: begin
        if (step) state_d = FETCH;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign halted  = (state_q == HALTED);
  assign retired = retired_q;

endmodule
